// File: rtl/rst_pulse_gen.sv
// Reset pulse generator: a one-cycle req drives a fixed-length active-low pulse on rst_out, then a hold-off gap.
// Define RST_PULSE_GEN_POR_EN to also issue a full pulse automatically when rst is released.
module rst_pulse_gen #(
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       rst_out,
  output logic       busy,
  output logic       done,
  output logic       req_drop,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLDOFF_CYCLES - 1);

`ifdef RST_PULSE_GEN_POR_EN
  localparam state_t RESET_STATE = ASSERT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 rst_out_nxt, busy_nxt, done_nxt, drop_nxt;

  // Handshake: req is a single-cycle strobe accepted only when busy is low;
  // a req seen while busy is discarded and reported on req_drop the next cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rst_out_nxt = rst_out;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    drop_nxt    = req && busy;
    case (state)
      IDLE: begin
        rst_out_nxt = 1'b1;
        busy_nxt    = 1'b0;
        if (req) begin
          state_nxt   = ASSERT;
          cnt_nxt     = '0;
          rst_out_nxt = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      ASSERT: begin
        rst_out_nxt = 1'b0;
        busy_nxt    = 1'b1;
        // busy low in ASSERT only on the first cycle after a power-on reset:
        // treat it as the entry cycle so the pulse is full length.
        if (!busy) begin
          cnt_nxt = '0;
        end else if (cnt == PULSE_LAST) begin
          rst_out_nxt = 1'b1;
          done_nxt    = 1'b1;
          cnt_nxt     = '0;
          if (HOLDOFF_CYCLES == 0) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = HOLDOFF;
          end
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      HOLDOFF: begin
        rst_out_nxt = 1'b1;
        busy_nxt    = 1'b1;
        if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        rst_out_nxt = 1'b1;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RESET_STATE;
      cnt      <= '0;
      rst_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rst_out  <= rst_out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      req_drop <= drop_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Directed bench for rst_pulse_gen: default instance plus a PULSE_CYCLES=1/HOLDOFF_CYCLES=0 instance.
// Edge e in the loops means the value present when edge e samples; inputs are set for edge e.
module tb_rst_pulse_gen;

  logic       clk;
  logic       rst;
  logic       req;
  logic       rst_out, busy, done, req_drop;
  logic [1:0] state_dbg;
  logic       s_rst_out, s_busy, s_done, s_req_drop;
  logic [1:0] s_state_dbg;

  int checks;
  int errors;
  logic [3:0] exp_v, act_v;

  rst_pulse_gen dut (
    .clk(clk), .rst(rst), .req(req),
    .rst_out(rst_out), .busy(busy), .done(done), .req_drop(req_drop),
    .state_dbg(state_dbg)
  );

  rst_pulse_gen #(.PULSE_CYCLES(1), .HOLDOFF_CYCLES(0), .CNT_WIDTH(8)) dut_s (
    .clk(clk), .rst(rst), .req(req),
    .rst_out(s_rst_out), .busy(s_busy), .done(s_done), .req_drop(s_req_drop),
    .state_dbg(s_state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e >= 3) begin
        exp_v = {(e >= 4), 1'b0, 1'b0, 1'b0};
        act_v = {rst_out, busy, done, req_drop};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL reset edge %0d: got %b expected %b (rst_out,busy,done,req_drop)", e, act_v, exp_v);
        end
      end
      rst = (e > 2);
      req = (e == 2);
    end
  endtask

  task automatic test_single();
    for (int e = 1; e <= 36; e++) begin
      @(negedge clk);
      if (e >= 3) begin
        exp_v = {!(e == 3 || (e >= 11 && e <= 26)), (e >= 11 && e <= 30), (e == 27), 1'b0};
        act_v = {rst_out, busy, done, req_drop};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL single edge %0d: got %b expected %b (rst_out,busy,done,req_drop)", e, act_v, exp_v);
        end
      end
      rst = (e > 2);
      req = (e == 10);
    end
  endtask

  task automatic test_drop();
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (e >= 3) begin
        exp_v = {!(e == 3 || (e >= 11 && e <= 26)), (e >= 11 && e <= 30), (e == 27), (e == 21)};
        act_v = {rst_out, busy, done, req_drop};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL drop edge %0d: got %b expected %b (rst_out,busy,done,req_drop)", e, act_v, exp_v);
        end
      end
      rst = (e > 2);
      req = (e == 10 || e == 20);
    end
  endtask

  task automatic test_held();
    int p, q;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      p = (e >= 11) ? (e - 11) % 21 : 99;
      q = (e >= 12) ? (e - 12) % 21 : 99;
      if (e >= 3) begin
        exp_v = {!(e == 3 || p <= 15), (p <= 19), (p == 16), (q <= 19)};
        act_v = {rst_out, busy, done, req_drop};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL held edge %0d: got %b expected %b (rst_out,busy,done,req_drop)", e, act_v, exp_v);
        end
      end
      rst = (e > 2);
      req = (e >= 10);
    end
  endtask

  task automatic test_reset_abort();
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (e >= 3) begin
        exp_v = {!(e == 3 || (e >= 11 && e <= 20)), (e >= 11 && e <= 18), 1'b0, 1'b0};
        act_v = {rst_out, busy, done, req_drop};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL abort edge %0d: got %b expected %b (rst_out,busy,done,req_drop)", e, act_v, exp_v);
        end
      end
      rst = !(e <= 2 || e == 18 || e == 19);
      req = (e == 10 || e == 19);
    end
  endtask

  task automatic test_back_to_back_short();
    for (int e = 1; e <= 22; e++) begin
      @(negedge clk);
      if (e >= 3) begin
        exp_v = {!(e == 3 || e == 11 || e == 15), (e == 11 || e == 15), (e == 12 || e == 16), (e == 16)};
        act_v = {s_rst_out, s_busy, s_done, s_req_drop};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL short edge %0d: got %b expected %b (rst_out,busy,done,req_drop)", e, act_v, exp_v);
        end
      end
      rst = (e > 2);
      req = (e == 10 || e == 14 || e == 15);
    end
  endtask

  task automatic test_por();
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      if (e >= 2) begin
        exp_v = {!(e <= 21), (e >= 6 && e <= 25), (e == 22), (e == 25)};
        act_v = {rst_out, busy, done, req_drop};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL por edge %0d: got %b expected %b (rst_out,busy,done,req_drop)", e, act_v, exp_v);
        end
        exp_v = {!(e <= 6 || e == 25), (e == 6 || e == 25), (e == 7 || e == 26), 1'b0};
        act_v = {s_rst_out, s_busy, s_done, s_req_drop};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL por_short edge %0d: got %b expected %b (rst_out,busy,done,req_drop)", e, act_v, exp_v);
        end
      end
      rst = (e >= 5);
      req = (e == 24);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    req    = 1'b0;
`ifdef RST_PULSE_GEN_POR_EN
    test_por();
`else
    test_reset();
    test_single();
    test_drop();
    test_held();
    test_reset_abort();
    test_back_to_back_short();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
